// File: rtl/uart_pkg.sv
// Shared UART definitions for the RX and TX paths: FSM states and frame constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_state_e;

    localparam int   FRAME_DATA_BITS = 8;
    localparam logic STOP_LEVEL      = 1'b1;

endpackage

// File: rtl/uart_word_rx_if.sv
// Consumer-side bus of the word receiver: the assembled word, the ready handshake and the error pulses.
interface uart_word_rx_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rdy;
    logic                  rdy_clr;
    logic                  overrun;
    logic                  frame_err;

    modport master (output data_out, output rdy, output overrun, output frame_err, input rdy_clr);
    modport slave  (input data_out, input rdy, input overrun, input frame_err, output rdy_clr);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input pin; RESET_VAL is the pin's idle level.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= RESET_VAL;
            q_o    <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end
endmodule

// File: rtl/uart_word_rx.sv
// Receives a 16-bit word as two oversampled UART frames, low byte first.
//   state     | meaning
//   IDLE      | line high, waiting for a start edge; runs the inter-byte timeout after a low byte
//   START     | checking the start bit at its centre (glitch filter)
//   DATA      | sampling 8 data bits at bit centres, LSB first
//   STOP      | sampling the stop bit
//   WAIT_HIGH | after a framing error, waiting for the line to return high
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int OVERSAMPLE   = 16,
    parameter int WORD_TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           clken,
    input  logic           rx,
    uart_word_rx_if.master bus
);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int TOW = $clog2(OVERSAMPLE * WORD_TIMEOUT);
    localparam logic [TW-1:0]  T_HALF  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]  T_FULL  = TW'(OVERSAMPLE - 1);
    localparam logic [TOW-1:0] TO_LOAD = TOW'(OVERSAMPLE * WORD_TIMEOUT - 1);

    logic                       rx_s;
    uart_state_e                state_q, state_d;
    logic [TW-1:0]              tcnt_q, tcnt_d;
    logic [2:0]                 bcnt_q, bcnt_d;
    logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
    logic [FRAME_DATA_BITS-1:0] lo_q, lo_d;
    logic                       byte_idx_q, byte_idx_d;
    logic [TOW-1:0]             to_q, to_d;
    logic [DATA_WIDTH-1:0]      data_q, data_d;
    logic                       rdy_q, rdy_d;
    logic                       ovr_q, ovr_d;
    logic                       ferr_q, ferr_d;

    uart_sync2 #(.RESET_VAL(STOP_LEVEL)) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (rx),
        .q_o  (rx_s)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            tcnt_q     <= '0;
            bcnt_q     <= '0;
            shift_q    <= '0;
            lo_q       <= '0;
            byte_idx_q <= 1'b0;
            to_q       <= '0;
            data_q     <= '0;
            rdy_q      <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            bcnt_q     <= bcnt_d;
            shift_q    <= shift_d;
            lo_q       <= lo_d;
            byte_idx_q <= byte_idx_d;
            to_q       <= to_d;
            data_q     <= data_d;
            rdy_q      <= rdy_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        bcnt_d     = bcnt_q;
        shift_d    = shift_q;
        lo_d       = lo_q;
        byte_idx_d = byte_idx_q;
        to_d       = to_q;
        data_d     = data_q;
        rdy_d      = rdy_q & ~bus.rdy_clr;
        ovr_d      = 1'b0;
        ferr_d     = 1'b0;
        if (clken) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        tcnt_d  = '0;
                    end else if (byte_idx_q) begin
                        // Down-counter loaded when the low byte lands; terminal count drops it.
                        if (to_q == '0) begin
                            ferr_d     = 1'b1;
                            byte_idx_d = 1'b0;
                        end else begin
                            to_d = to_q - TOW'(1);
                        end
                    end
                end
                START: begin
                    if (tcnt_q == T_HALF) begin
                        tcnt_d = '0;
                        if (!rx_s) begin
                            state_d = DATA;
                            bcnt_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                DATA: begin
                    if (tcnt_q == T_FULL) begin
                        tcnt_d  = '0;
                        shift_d = {rx_s, shift_q[FRAME_DATA_BITS-1:1]};
                        bcnt_d  = bcnt_q + 3'd1;
                        if (bcnt_q == 3'd7) state_d = STOP;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                STOP: begin
                    if (tcnt_q == T_FULL) begin
                        tcnt_d = '0;
                        if (rx_s == STOP_LEVEL) begin
                            state_d = IDLE;
                            if (!byte_idx_q) begin
                                lo_d       = shift_q;
                                byte_idx_d = 1'b1;
                                to_d       = TO_LOAD;
                            end else begin
                                data_d     = {shift_q, lo_q};
                                rdy_d      = 1'b1;
                                // A simultaneous clear acknowledged the old word, so no overrun.
                                ovr_d      = rdy_q & ~bus.rdy_clr;
                                byte_idx_d = 1'b0;
                            end
                        end else begin
                            ferr_d     = 1'b1;
                            byte_idx_d = 1'b0;
                            state_d    = WAIT_HIGH;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.data_out  = data_q;
    assign bus.rdy       = rdy_q;
    assign bus.overrun   = ovr_q;
    assign bus.frame_err = ferr_q;
endmodule
